// File: rtl/rx_vc_buf.sv
// Per-VC receive buffer: one flit FIFO per virtual channel with packet tracking and a VC-selectable pop port.
// Latency: a push becomes visible on the read port one cycle later; read outputs are combinational from registered state.
// Backpressure: in_ready_o drops while the addressed VC FIFO is full, from the registered full flag only (no pop bypass).
//
// Ports:
//   clk_axi, arst_axi          clock, asynchronous active-high reset
//   in_valid_i/in_ready_o      flit push handshake; in_data_i, in_vc_i, in_ftype_i describe the flit
//   rd_vc_i, rd_ready_i        pop select and pop request
//   rd_valid_o/rd_data_o/rd_last_o  head flit of the selected VC (zeroed when empty)
//   vc_empty_o, vc_full_o, pkt_avail_o  per-VC status from registered counters
//   proto_err_o                registered one-cycle pulse on a flit-type sequence violation
module rx_vc_buf #(
    parameter int NumVC         = 3,
    parameter int FlitDataWidth = 32,
    parameter int BufDepth      = 8,
    parameter int PktWidth      = 8,
    parameter int PktSzLsb      = 0,
    localparam int VcWidth      = $clog2(NumVC),
    localparam int PtrW         = $clog2(BufDepth),
    localparam int CntW         = $clog2(BufDepth + 1)
) (
    input  logic                     clk_axi,
    input  logic                     arst_axi,
    input  logic                     in_valid_i,
    input  logic [FlitDataWidth-1:0] in_data_i,
    input  logic [VcWidth-1:0]       in_vc_i,
    input  logic [1:0]               in_ftype_i,
    output logic                     in_ready_o,
    input  logic [VcWidth-1:0]       rd_vc_i,
    input  logic                     rd_ready_i,
    output logic                     rd_valid_o,
    output logic [FlitDataWidth-1:0] rd_data_o,
    output logic                     rd_last_o,
    output logic [NumVC-1:0]         vc_empty_o,
    output logic [NumVC-1:0]         vc_full_o,
    output logic [NumVC-1:0]         pkt_avail_o,
    output logic                     proto_err_o
);

    // Flit type codes; 2'b01 (BODY) and 2'b11 (illegal, handled as BODY)
    // both fall through as "not HEAD, not TAIL".
    localparam logic [1:0]      FtHead  = 2'b00;
    localparam logic [1:0]      FtTail  = 2'b10;
    localparam logic [1:0]      FtBad   = 2'b11;
    localparam logic [CntW-1:0] FullCnt = CntW'(BufDepth);

    // Storage entry is {last, payload}. Not reset: the empty gating hides it.
    logic [FlitDataWidth:0] mem_q [NumVC][BufDepth];

    logic [NumVC-1:0][PtrW-1:0] wr_ptr_q, wr_ptr_d;
    logic [NumVC-1:0][PtrW-1:0] rd_ptr_q, rd_ptr_d;
    logic [NumVC-1:0][CntW-1:0] occ_q, occ_d;
    logic [NumVC-1:0][CntW-1:0] pkt_cnt_q, pkt_cnt_d;
    logic [NumVC-1:0]           open_q, open_d;
    logic                       proto_err_q, proto_err_d;

    logic                       is_head, is_tail, size_zero, in_last, in_err;
    logic                       push, pop, sel_open;
    logic [NumVC-1:0]           push_v, pop_v;
    logic [FlitDataWidth:0]     rd_ent;

    // ------------------------------------------------------------------
    // Status flags from registered counters only
    // ------------------------------------------------------------------
    always_comb begin
        vc_empty_o  = '0;
        vc_full_o   = '0;
        pkt_avail_o = '0;
        for (int v = 0; v < NumVC; v++) begin
            vc_empty_o[v]  = (occ_q[v] == '0);
            vc_full_o[v]   = (occ_q[v] == FullCnt);
            pkt_avail_o[v] = (pkt_cnt_q[v] != '0);
        end
    end

    // ------------------------------------------------------------------
    // VC select muxes for the push and pop sides. Compare-and-select
    // instead of direct indexing so an unused VC code (when NumVC is not
    // a power of two) reads as "not ready" / "not valid".
    // ------------------------------------------------------------------
    always_comb begin
        in_ready_o = 1'b0;
        sel_open   = 1'b0;
        rd_valid_o = 1'b0;
        rd_ent     = '0;
        for (int v = 0; v < NumVC; v++) begin
            if (in_vc_i == VcWidth'(v)) begin
                in_ready_o = ~vc_full_o[v];
                sel_open   = open_q[v];
            end
            if (rd_vc_i == VcWidth'(v)) begin
                rd_valid_o = ~vc_empty_o[v];
                rd_ent     = mem_q[v][rd_ptr_q[v]];
            end
        end
        rd_data_o = rd_valid_o ? rd_ent[FlitDataWidth-1:0] : '0;
        rd_last_o = rd_valid_o & rd_ent[FlitDataWidth];
    end

    // ------------------------------------------------------------------
    // Flit decode and protocol check
    // ------------------------------------------------------------------
    always_comb begin
        is_head   = (in_ftype_i == FtHead);
        is_tail   = (in_ftype_i == FtTail);
        size_zero = (in_data_i[PktSzLsb +: PktWidth] == '0);
        // A HEAD with a zero size field is a complete single-flit packet.
        in_last   = is_tail | (is_head & size_zero);
        // HEAD must arrive on a closed VC, everything else on an open one.
        in_err    = (in_ftype_i == FtBad) | (is_head ? sel_open : ~sel_open);
        push      = in_valid_i & in_ready_o;
        pop       = rd_valid_o & rd_ready_i;
    end

    // ------------------------------------------------------------------
    // Per-VC next state
    // ------------------------------------------------------------------
    always_comb begin
        push_v = '0;
        pop_v  = '0;
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        occ_d     = occ_q;
        pkt_cnt_d = pkt_cnt_q;
        open_d    = open_q;
        for (int v = 0; v < NumVC; v++) begin
            push_v[v] = push & (in_vc_i == VcWidth'(v));
            pop_v[v]  = pop & (rd_vc_i == VcWidth'(v));

            wr_ptr_d[v]  = wr_ptr_q[v] + PtrW'(push_v[v]);
            rd_ptr_d[v]  = rd_ptr_q[v] + PtrW'(pop_v[v]);
            occ_d[v]     = occ_q[v] + CntW'(push_v[v]) - CntW'(pop_v[v]);
            // Packet count follows the last marker on both sides; a
            // same-cycle inc and dec cancel out.
            pkt_cnt_d[v] = pkt_cnt_q[v] + CntW'(push_v[v] & in_last)
                                        - CntW'(pop_v[v] & rd_last_o);

            // The open bit tracks the flit types even on a violation, so
            // the checker resynchronises to whatever the sender is doing.
            if (push_v[v]) begin
                if (is_head && !size_zero) begin
                    open_d[v] = 1'b1;
                end else if (is_tail) begin
                    open_d[v] = 1'b0;
                end
            end
        end
        proto_err_d = push & in_err;
    end

    // ------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk_axi or posedge arst_axi) begin
        if (arst_axi) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            occ_q       <= '0;
            pkt_cnt_q   <= '0;
            open_q      <= '0;
            proto_err_q <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            occ_q       <= occ_d;
            pkt_cnt_q   <= pkt_cnt_d;
            open_q      <= open_d;
            proto_err_q <= proto_err_d;
        end
    end

    always_ff @(posedge clk_axi) begin
        for (int v = 0; v < NumVC; v++) begin
            if (push_v[v]) begin
                mem_q[v][wr_ptr_q[v]] <= {in_last, in_data_i};
            end
        end
    end

    assign proto_err_o = proto_err_q;

endmodule

// File: tb/tb_rx_vc_buf.sv
module tb_rx_vc_buf;

    localparam int NV = 3;
    localparam int DW = 32;
    localparam int D  = 8;

    localparam logic [1:0] HEAD = 2'b00;
    localparam logic [1:0] BODY = 2'b01;
    localparam logic [1:0] TAIL = 2'b10;
    localparam logic [1:0] BAD  = 2'b11;

    logic          clk_axi = 1'b0;
    logic          arst_axi;
    logic          in_valid_i;
    logic [DW-1:0] in_data_i;
    logic [1:0]    in_vc_i;
    logic [1:0]    in_ftype_i;
    logic          in_ready_o;
    logic [1:0]    rd_vc_i;
    logic          rd_ready_i;
    logic          rd_valid_o;
    logic [DW-1:0] rd_data_o;
    logic          rd_last_o;
    logic [NV-1:0] vc_empty_o;
    logic [NV-1:0] vc_full_o;
    logic [NV-1:0] pkt_avail_o;
    logic          proto_err_o;

    rx_vc_buf #(
        .NumVC(NV), .FlitDataWidth(DW), .BufDepth(D), .PktWidth(8), .PktSzLsb(0)
    ) dut (
        .clk_axi(clk_axi), .arst_axi(arst_axi),
        .in_valid_i(in_valid_i), .in_data_i(in_data_i), .in_vc_i(in_vc_i),
        .in_ftype_i(in_ftype_i), .in_ready_o(in_ready_o),
        .rd_vc_i(rd_vc_i), .rd_ready_i(rd_ready_i), .rd_valid_o(rd_valid_o),
        .rd_data_o(rd_data_o), .rd_last_o(rd_last_o),
        .vc_empty_o(vc_empty_o), .vc_full_o(vc_full_o), .pkt_avail_o(pkt_avail_o),
        .proto_err_o(proto_err_o)
    );

    always #5 clk_axi = ~clk_axi;

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Reference model: one shared list of stored flits tagged by VC.
    // Occupancy, head and packet availability are derived by scanning it.
    // ------------------------------------------------------------------
    typedef struct packed {
        logic [1:0]    vc;
        logic          last;
        logic [DW-1:0] data;
    } ent_t;

    ent_t mq[$];
    bit   m_open[NV];
    bit   m_err;

    function automatic int occ(input int v);
        int n = 0;
        for (int i = 0; i < mq.size(); i++) if (int'(mq[i].vc) == v) n++;
        return n;
    endfunction

    function automatic int head_idx(input int v);
        for (int i = 0; i < mq.size(); i++) if (int'(mq[i].vc) == v) return i;
        return -1;
    endfunction

    function automatic bit has_pkt(input int v);
        for (int i = 0; i < mq.size(); i++) if (int'(mq[i].vc) == v && mq[i].last) return 1'b1;
        return 1'b0;
    endfunction

    task automatic model_clear();
        mq.delete();
        for (int v = 0; v < NV; v++) m_open[v] = 1'b0;
        m_err = 1'b0;
    endtask

    // Applies the current inputs to the model as one clock edge.
    task automatic model_update();
        bit   pu, po, hd, tl, sz0;
        int   h, v;
        ent_t e;
        v  = int'(in_vc_i);
        pu = in_valid_i && (occ(v) < D);
        h  = head_idx(int'(rd_vc_i));
        po = rd_ready_i && (h >= 0);
        m_err = 1'b0;
        e = '0;
        if (pu) begin
            hd  = (in_ftype_i == HEAD);
            tl  = (in_ftype_i == TAIL);
            sz0 = (in_data_i[7:0] == 8'h00);
            e.vc   = in_vc_i;
            e.data = in_data_i;
            e.last = tl || (hd && sz0);
            m_err  = (in_ftype_i == BAD) || (hd ? m_open[v] : !m_open[v]);
            if (hd && !sz0) m_open[v] = 1'b1;
            else if (tl)    m_open[v] = 1'b0;
        end
        if (po) mq.delete(h);
        if (pu) mq.push_back(e);
    endtask

    task automatic check_all();
        int            h;
        logic [NV-1:0] e_emp, e_full, e_pav;
        h = head_idx(int'(rd_vc_i));
        for (int v = 0; v < NV; v++) begin
            e_emp[v]  = (occ(v) == 0);
            e_full[v] = (occ(v) == D);
            e_pav[v]  = has_pkt(v);
        end
        chk("in_ready",  64'(in_ready_o), 64'(occ(int'(in_vc_i)) < D));
        chk("rd_valid",  64'(rd_valid_o), 64'(h >= 0));
        chk("rd_data",   64'(rd_data_o),  (h >= 0) ? 64'(mq[h].data) : 64'd0);
        chk("rd_last",   64'(rd_last_o),  (h >= 0) ? 64'(mq[h].last) : 64'd0);
        chk("vc_empty",  64'(vc_empty_o), 64'(e_emp));
        chk("vc_full",   64'(vc_full_o),  64'(e_full));
        chk("pkt_avail", 64'(pkt_avail_o), 64'(e_pav));
        chk("proto_err", 64'(proto_err_o), 64'(m_err));
    endtask

    task automatic drive(input logic vld, input logic [1:0] vc, input logic [1:0] ft,
                         input logic [DW-1:0] dat, input logic [1:0] rvc, input logic rrdy);
        in_valid_i = vld;
        in_vc_i    = vc;
        in_ftype_i = ft;
        in_data_i  = dat;
        rd_vc_i    = rvc;
        rd_ready_i = rrdy;
    endtask

    // Inputs are driven at edge+1; outputs are sampled at edge+3.
    task automatic step();
        #2;
        check_all();
        @(posedge clk_axi);
        model_update();
        #1;
    endtask

    typedef struct {
        logic          vld;
        logic [1:0]    vc;
        logic [1:0]    ft;
        logic [DW-1:0] dat;
        logic [1:0]    rvc;
        logic          rrdy;
        logic          e_irdy;
        logic          e_rvld;
        logic [DW-1:0] e_rdat;
        logic          e_rlast;
        logic [2:0]    e_pav;
        logic          e_err;
    } vec_t;

    vec_t tv[7];
    int   pulses;

    initial begin
        // Single 3-flit packet on VC1; expectations are what is seen
        // before the edge of the row, with that row's inputs applied.
        tv[0] = '{1'b1, 2'd1, HEAD, 32'h2,  2'd1, 1'b0, 1'b1, 1'b0, 32'h0,  1'b0, 3'b000, 1'b0};
        tv[1] = '{1'b1, 2'd1, BODY, 32'hA5, 2'd1, 1'b0, 1'b1, 1'b1, 32'h2,  1'b0, 3'b000, 1'b0};
        tv[2] = '{1'b1, 2'd1, TAIL, 32'h5A, 2'd1, 1'b0, 1'b1, 1'b1, 32'h2,  1'b0, 3'b000, 1'b0};
        tv[3] = '{1'b0, 2'd1, BODY, 32'h0,  2'd1, 1'b1, 1'b1, 1'b1, 32'h2,  1'b0, 3'b010, 1'b0};
        tv[4] = '{1'b0, 2'd1, BODY, 32'h0,  2'd1, 1'b1, 1'b1, 1'b1, 32'hA5, 1'b0, 3'b010, 1'b0};
        tv[5] = '{1'b0, 2'd1, BODY, 32'h0,  2'd1, 1'b1, 1'b1, 1'b1, 32'h5A, 1'b1, 3'b010, 1'b0};
        tv[6] = '{1'b0, 2'd1, BODY, 32'h0,  2'd1, 1'b0, 1'b1, 1'b0, 32'h0,  1'b0, 3'b000, 1'b0};

        arst_axi = 1'b1;
        drive(1'b0, 2'd0, HEAD, '0, 2'd0, 1'b0);
        model_clear();
        #1;
        chk("por_in_ready", 64'(in_ready_o), 64'd1);
        chk("por_vc_empty", 64'(vc_empty_o), 64'h7);
        #11;
        arst_axi = 1'b0;
        @(posedge clk_axi);
        #1;

        // ---- single packet on VC1 (table) ----
        for (int i = 0; i < 7; i++) begin
            drive(tv[i].vld, tv[i].vc, tv[i].ft, tv[i].dat, tv[i].rvc, tv[i].rrdy);
            #2;
            chk($sformatf("tv%0d_in_ready", i),  64'(in_ready_o),  64'(tv[i].e_irdy));
            chk($sformatf("tv%0d_rd_valid", i),  64'(rd_valid_o),  64'(tv[i].e_rvld));
            chk($sformatf("tv%0d_rd_data", i),   64'(rd_data_o),   64'(tv[i].e_rdat));
            chk($sformatf("tv%0d_rd_last", i),   64'(rd_last_o),   64'(tv[i].e_rlast));
            chk($sformatf("tv%0d_pkt_avail", i), 64'(pkt_avail_o), 64'(tv[i].e_pav));
            chk($sformatf("tv%0d_proto_err", i), 64'(proto_err_o), 64'(tv[i].e_err));
            @(posedge clk_axi);
            model_update();
            #1;
        end

        // ---- fill VC0 with 8 single-flit packets ----
        for (int i = 0; i < D; i++) begin
            drive(1'b1, 2'd0, HEAD, 32'((i + 1) << 8), 2'd1, 1'b0);
            step();
        end
        drive(1'b1, 2'd0, HEAD, 32'h0, 2'd1, 1'b0);
        #2;
        chk("full_vc0_flag", 64'(vc_full_o[0]), 64'd1);
        chk("full_vc0_ready", 64'(in_ready_o), 64'd0);
        chk("full_vc0_pkt_avail", 64'(pkt_avail_o[0]), 64'd1);
        #1;
        drive(1'b1, 2'd2, HEAD, 32'h0000_7700, 2'd1, 1'b0);
        #1;
        chk("vc2_ready_while_vc0_full", 64'(in_ready_o), 64'd1);
        step();
        chk("vc2_accepted", 64'(vc_empty_o[2]), 64'd0);

        // ---- push+pop on a full VC: push refused, occupancy 8 -> 7 ----
        drive(1'b1, 2'd0, HEAD, 32'h0000_EE00, 2'd0, 1'b1);
        step();
        chk("full_pushpop_not_full", 64'(vc_full_o[0]), 64'd0);
        for (int i = 0; i < D - 1; i++) begin
            drive(1'b0, 2'd0, HEAD, 32'h0, 2'd0, 1'b1);
            step();
        end
        chk("full_pushpop_occ7_drained", 64'(vc_empty_o[0]), 64'd1);
        chk("vc0_pkts_gone", 64'(pkt_avail_o[0]), 64'd0);

        // ---- half-full VC1: push last and pop last together ----
        for (int i = 0; i < D / 2; i++) begin
            drive(1'b1, 2'd1, HEAD, 32'((i + 16) << 8), 2'd1, 1'b0);
            step();
        end
        drive(1'b1, 2'd1, HEAD, 32'h0000_AB00, 2'd1, 1'b1);
        step();
        for (int i = 0; i < D / 2; i++) begin
            chk($sformatf("same_cycle_pkt_avail%0d", i), 64'(pkt_avail_o[1]), 64'd1);
            drive(1'b0, 2'd1, HEAD, 32'h0, 2'd1, 1'b1);
            step();
        end
        chk("same_cycle_pkt_cnt_drained", 64'(pkt_avail_o[1]), 64'd0);

        // ---- wrap-around on VC2 (the leftover flit from above goes first) ----
        for (int i = 0; i < 20; i++) begin
            drive(1'b1, 2'd2, HEAD, 32'((i + 32) << 8), 2'd2, (i >= 3) ? 1'b1 : 1'b0);
            step();
        end
        for (int i = 0; i < 6; i++) begin
            drive(1'b0, 2'd2, HEAD, 32'h0, 2'd2, 1'b1);
            step();
        end
        chk("wrap_vc2_drained", 64'(vc_empty_o[2]), 64'd1);

        // ---- protocol errors on VC0 ----
        pulses = 0;
        drive(1'b1, 2'd0, BODY, 32'h11, 2'd0, 1'b0);
        step();
        pulses += int'(proto_err_o);
        drive(1'b1, 2'd0, HEAD, 32'h3, 2'd0, 1'b0);
        step();
        pulses += int'(proto_err_o);
        drive(1'b1, 2'd0, HEAD, 32'h4, 2'd0, 1'b0);
        step();
        pulses += int'(proto_err_o);
        drive(1'b0, 2'd0, HEAD, 32'h0, 2'd0, 1'b0);
        step();
        pulses += int'(proto_err_o);
        step();
        pulses += int'(proto_err_o);
        chk("proto_err_pulses", 64'(pulses), 64'd2);
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("err_flit%0d_stored", i), 64'(rd_valid_o), 64'd1);
            drive(1'b0, 2'd0, HEAD, 32'h0, 2'd0, 1'b1);
            step();
        end
        chk("err_flits_drained", 64'(vc_empty_o[0]), 64'd1);

        // ---- randomized traffic against the model ----
        for (int i = 0; i < 600; i++) begin
            logic [DW-1:0] d;
            d = $urandom;
            if ($urandom_range(1, 0) == 0) d[7:0] = 8'h00;
            drive(1'($urandom_range(1, 0)), 2'($urandom_range(2, 0)), 2'($urandom_range(3, 0)),
                  d, 2'($urandom_range(2, 0)), ($urandom_range(2, 0) == 0) ? 1'b1 : 1'b0);
            step();
        end

        // ---- reset mid-stream ----
        drive(1'b1, 2'd1, HEAD, 32'h5, 2'd1, 1'b0);
        step();
        arst_axi = 1'b1;
        drive(1'b0, 2'd1, BODY, 32'h0, 2'd1, 1'b0);
        #1;
        model_clear();
        chk("rst_in_ready", 64'(in_ready_o), 64'd1);
        chk("rst_vc_empty", 64'(vc_empty_o), 64'h7);
        chk("rst_vc_full", 64'(vc_full_o), 64'h0);
        chk("rst_rd_valid", 64'(rd_valid_o), 64'd0);
        chk("rst_rd_data", 64'(rd_data_o), 64'd0);
        chk("rst_pkt_avail", 64'(pkt_avail_o), 64'h0);
        chk("rst_proto_err", 64'(proto_err_o), 64'd0);
        @(posedge clk_axi);
        #1;
        arst_axi = 1'b0;
        // First flit after reset: BODY on a closed VC must flag an error.
        drive(1'b1, 2'd1, BODY, 32'h99, 2'd1, 1'b0);
        step();
        drive(1'b0, 2'd1, BODY, 32'h0, 2'd1, 1'b1);
        step();
        step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/rx_vc_buf.md
# rx_vc_buf

Per-virtual-channel receive buffer on the NoC-to-AXI path of the network interface. It accepts flits from the packet processor's receive side, with the flit type already separated from the payload, and stores them in one FIFO per VC. It tracks complete packets per VC and presents a selectable-VC pop interface to the AXI slave read-data logic. Backpressure is applied per VC through `in_ready_o`, which feeds the router's local ready.

## Interface

**Parameters**
- `NumVC`, default 3: number of virtual channels (≥2).
- `FlitDataWidth`, default 32: payload width, with the type bits stripped.
- `BufDepth`, default 8: flits per VC FIFO; power of two, ≥2.
- `PktWidth`, default 8: width of the in-band packet-size field in HEAD flits.
- `PktSzLsb`, default 0: LSB position of the size field within HEAD payload.
- Derived parameters:
  - `VcWidth = $clog2(NumVC)`
  - `PtrW = $clog2(BufDepth)`
  - `CntW = $clog2(BufDepth+1)`

**Ports**
- `clk_axi`, in, 1: clock.
- `arst_axi`, in, 1: reset; asynchronous, active-high.
- `in_valid_i`, in, 1: incoming flit valid.
- `in_data_i`, in, FlitDataWidth: flit payload.
- `in_vc_i`, in, VcWidth: target VC of the flit.
- `in_ftype_i`, in, 2: flit type; 2'b00 HEAD, 2'b01 BODY, 2'b10 TAIL.
- `in_ready_o`, out, 1: the FIFO of `in_vc_i` is not full.
- `rd_vc_i`, in, VcWidth: VC selected for popping.
- `rd_ready_i`, in, 1: consumer pops the head of the `rd_vc_i` FIFO.
- `rd_valid_o`, out, 1: the selected VC FIFO is non-empty.
- `rd_data_o`, out, FlitDataWidth: head payload of the selected VC; 0 when `rd_valid_o`=0.
- `rd_last_o`, out, 1: the head flit closes its packet; 0 when `rd_valid_o`=0.
- `vc_empty_o`, out, NumVC: per-VC empty flag.
- `vc_full_o`, out, NumVC: per-VC full flag.
- `pkt_avail_o`, out, NumVC: per-VC flag, at least one complete packet stored.
- `proto_err_o`, out, 1: one-cycle pulse on a flit-type sequence violation.

## Operation

**Storage**
- Each VC has a FIFO of `BufDepth` × (FlitDataWidth+1) entries; the extra bit is `last`.
- Each FIFO keeps a write pointer, a read pointer and an occupancy counter (CntW bits). Pointers wrap modulo `BufDepth`.

**Push**
- A push happens when `in_valid_i & in_ready_o`. It writes `{last, in_data_i}` at `wr_ptr[in_vc_i]`.
- `last` = (type TAIL) OR (type HEAD AND `in_data_i[PktSzLsb +: PktWidth]` == 0). The second case is a single-flit packet.
- Type 2'b11 is treated as BODY and raises `proto_err_o`.

**Per-VC packet state**
- Each VC has an `open` bit, set while a multi-flit packet is in progress.
- HEAD with size > 0 sets `open`. TAIL clears it.
- A violation raises `proto_err_o` for one cycle. Violations are:
  - HEAD while `open`=1
  - BODY or TAIL while `open`=0
- On any violation the flit is still stored and the normal `open` update is applied.

**Packet counter**
- Each VC has a `pkt_cnt` (CntW bits).
- It increments on a push with `last`=1 and decrements on a pop with `last`=1.
- A simultaneous increment and decrement on the same VC leaves it unchanged.
- `pkt_avail_o[v]` = (`pkt_cnt[v]` != 0).

**Pop**
- A pop happens when `rd_valid_o & rd_ready_i`. It advances `rd_ptr[rd_vc_i]`.
- The read path is combinational from storage, muxed by `rd_vc_i`.

**Simultaneous push and pop on the same VC**
- Occupancy is unchanged and both pointers advance.
- A full FIFO does not accept a push in the cycle it is popped; `in_ready_o` depends on the registered full flag only, with no bypass.

**Other rules**
- Pushes and pops on different VCs are fully independent.
- `rd_vc_i` may change every cycle; the outputs follow combinationally.

## Timing

**Reset** (asynchronous on `arst_axi`)
- All pointers, occupancy counters, `pkt_cnt` and `open` bits clear to 0.
- Output values in reset:
  - `in_ready_o`=1
  - `rd_valid_o`=0, `rd_data_o`=0, `rd_last_o`=0
  - `vc_empty_o`=all 1, `vc_full_o`=all 0, `pkt_avail_o`=0
  - `proto_err_o`=0
- Storage contents are not reset; the output gating hides them.
- Reset asserted mid-packet discards all stored flits and open packets.

**Latency**
- Push to visibility: 1 cycle. A flit pushed at edge N gives `rd_valid_o`=1 after edge N when its VC is selected.
- `in_ready_o`, `rd_valid_o`, `rd_data_o` and `rd_last_o` are combinational from registered state and the selects.
- `vc_empty_o`, `vc_full_o` and `pkt_avail_o` are derived combinationally from registered counters only.
- `proto_err_o` is registered: it is high in the cycle after the offending push.

**Handshake**
- `in_data_i`, `in_vc_i` and `in_ftype_i` are sampled only when `in_valid_i & in_ready_o`.
- `in_ready_o` may deassert while `in_valid_i` is held; the sender keeps the flit stable until it is accepted.

**Boundaries**
- Full: occupancy == `BufDepth`. Empty: occupancy == 0.
- A pop on an empty VC (`rd_ready_i` with `rd_valid_o`=0) is ignored.
- `pkt_cnt` cannot exceed `BufDepth`, because each counted packet holds at least one stored flit.

## Test plan

1. **Reset values.** Assert `arst_axi` mid-stream, then release. Require `in_ready_o`=1, `vc_empty_o`=3'b111, `rd_valid_o`=0, `pkt_avail_o`=0.
2. **Single packet on VC1.** Push HEAD (size field 2), BODY 0xA5, TAIL 0x5A; select VC1 and pop 3. Require:
   - `pkt_avail_o`=3'b010 after the TAIL push;
   - data returned in order;
   - `rd_last_o`=1 only on 0x5A;
   - `pkt_avail_o`=0 after the last pop.
3. **Full VC0, other VCs unaffected.** Push 8 HEAD flits with size 0 to VC0. Require:
   - `vc_full_o[0]`=1 and `in_ready_o`=0 for VC0;
   - a push to VC2 is still accepted;
   - `pkt_cnt[0]`=8, with `pkt_avail_o[0]`=1.
4. **Simultaneous push and pop.**
   - On a full VC: `in_ready_o` stays 0 and occupancy drops to 7.
   - On a half-full VC with a push of the last flit and a pop of a last flit in the same cycle: `pkt_cnt` is unchanged.
5. **Wrap-around.** Run 20 interleaved push/pop flits on VC2. Require data order preserved across pointer wrap, with no false full/empty indication.
6. **Protocol errors.** Push BODY on an idle VC, then HEAD(size 3) followed by HEAD. Require one `proto_err_o` pulse per violation and every flit still stored.
